// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, funct and ALU codes, control-FSM states.
// Imported by the control FSM and by the datapath.
package cpu_defs_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/wb sequencing.
// Ports: clk, rst (async active-low), run, op_control, funct_control,
//   zero -> store, w_reg, w_data, op_alu, state, illegal, instr_count.
module cpu_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       op_control,
  input  logic [5:0]       funct_control,
  input  logic             zero,
  output logic             store,
  output logic             w_reg,
  output logic             w_data,
  output logic [5:0]       op_alu,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e state_q;
  state_e state_d;
  logic   go_halt;

  // The branch decision lives in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  logic is_j;
  logic is_beq;
  logic is_ls;
  logic is_lw;
  logic is_sw;
  logic is_alu;

  assign is_j   = op_control == OP_J;
  assign is_beq = op_control == OP_BEQ;
  assign is_lw  = op_control == OP_LW;
  assign is_sw  = op_control == OP_SW;
  assign is_ls  = is_lw | is_sw;
  assign is_alu = (op_control == OP_ADDI)
                | ((op_control == OP_R)
                   & (funct_control == FUNCT_ADD));

  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    w_reg   = 1'b0;
    w_data  = 1'b0;
    op_alu  = ALU_ADD;
    go_halt = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_beq) op_alu = ALU_SUB;
        unique case (1'b1)
          is_j: begin
            store   = 1'b1;
            state_d = S_FETCH;
          end
          (is_beq | is_ls | is_alu): begin
            state_d = S_EXEC;
          end
          default: begin
            state_d = S_HALT;
            go_halt = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (is_beq) op_alu = ALU_SUB;
        unique case (1'b1)
          is_beq: begin
            store   = 1'b1;
            state_d = S_FETCH;
          end
          is_ls:   state_d = S_MEM;
          is_alu:  state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        unique case (1'b1)
          is_sw: begin
            w_data  = 1'b1;
            store   = 1'b1;
            state_d = S_FETCH;
          end
          is_lw:   state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_WB: begin
        w_reg   = 1'b1;
        store   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (go_halt) illegal <= 1'b1;
      // Retire on the PC write; wraps naturally.
      if (store) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm.
// One task per scenario, inline comparisons, single summary line.
module tb_cpu_control_fsm;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          run;
  logic [5:0]    op_control;
  logic [5:0]    funct_control;
  logic          zero;
  logic          store;
  logic          w_reg;
  logic          w_data;
  logic [5:0]    op_alu;
  logic [2:0]    state;
  logic          illegal;
  logic [CW-1:0] instr_count;

  int total;
  int bad;
  logic [CW-1:0] exp_cnt;

  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_ADD  = 6'b100000;
  localparam logic [5:0] C_SUB  = 6'b100010;

  cpu_control_fsm #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .op_control    (op_control),
    .funct_control (funct_control),
    .zero          (zero),
    .store         (store),
    .w_reg         (w_reg),
    .w_data        (w_data),
    .op_alu        (op_alu),
    .state         (state),
    .illegal       (illegal),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  // Walk one instruction cycle by cycle; sequences are hand-written.
  task automatic step_instr(input string nm, input logic [5:0] op,
                            input logic [5:0] fn, input int n,
                            input logic [2:0] st [6],
                            input logic [5:0] stm, input logic [5:0] wrm,
                            input logic [5:0] wdm, input logic [5:0] subm);
    op_control = op;
    funct_control = fn;
    run = 1'b1;
    for (int c = 0; c < n; c++) begin
      logic [5:0] ea;
      ea = subm[c] ? C_SUB : C_ADD;
      total++;
      if (state !== st[c] || store !== stm[c] || w_reg !== wrm[c]
          || w_data !== wdm[c] || op_alu !== ea
          || instr_count !== exp_cnt) begin
        bad++;
        $display("FAIL %s c%0d: st=%0d s=%b wr=%b wd=%b alu=%b cnt=%0d exp st=%0d s=%b wr=%b wd=%b alu=%b cnt=%0d",
                 nm, c, state, store, w_reg, w_data, op_alu, instr_count,
                 st[c], stm[c], wrm[c], wdm[c], ea, exp_cnt);
      end
      if (c == n - 1) run = 1'b0;
      tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    total++;
    if (state !== 3'd0 || instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s retire: st=%0d cnt=%0d exp st=0 cnt=%0d",
               nm, state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b0;
    op_control = C_LW;
    funct_control = '0;
    zero = 1'b0;
    #3;
    total++;
    if (state !== 3'd0 || store !== 1'b0 || w_reg !== 1'b0
        || w_data !== 1'b0 || op_alu !== C_ADD || illegal !== 1'b0
        || instr_count !== '0) begin
      bad++;
      $display("FAIL reset: st=%0d s=%b wr=%b wd=%b alu=%b ill=%b cnt=%0d",
               state, store, w_reg, w_data, op_alu, illegal, instr_count);
    end
    tick();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_idle();
    run = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (state !== 3'd0 || store !== 1'b0 || w_reg !== 1'b0
          || w_data !== 1'b0 || instr_count !== '0) begin
        bad++;
        $display("FAIL idle c%0d: st=%0d s=%b wr=%b wd=%b cnt=%0d exp 0",
                 c, state, store, w_reg, w_data, instr_count);
      end
    end
  endtask

  task automatic test_lw();
    step_instr("lw", C_LW, 6'd0, 5, '{0, 1, 2, 3, 4, 0},
               6'b10000, 6'b10000, 6'b00000, 6'b00000);
  endtask

  task automatic test_sw();
    step_instr("sw", C_SW, 6'd0, 4, '{0, 1, 2, 3, 0, 0},
               6'b01000, 6'b00000, 6'b01000, 6'b00000);
  endtask

  task automatic test_beq();
    step_instr("beq", C_BEQ, 6'd0, 3, '{0, 1, 2, 0, 0, 0},
               6'b00100, 6'b00000, 6'b00000, 6'b00110);
  endtask

  task automatic test_add();
    step_instr("add", C_R, C_ADD, 4, '{0, 1, 2, 4, 0, 0},
               6'b01000, 6'b01000, 6'b00000, 6'b00000);
    step_instr("addi", C_ADDI, 6'd0, 4, '{0, 1, 2, 4, 0, 0},
               6'b01000, 6'b01000, 6'b00000, 6'b00000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    op_control = C_J;
    run = 1'b1;
    for (int c = 0; c < 32; c++) begin
      logic es;
      es = (c % 2) == 1;
      total++;
      if (store !== es || instr_count !== exp_cnt
          || state !== (es ? 3'd1 : 3'd0)) begin
        bad++;
        $display("FAIL jwrap c%0d: s=%b st=%0d cnt=%0d exp s=%b cnt=%0d",
                 c, store, state, instr_count, es, exp_cnt);
      end
      tick();
      if (es) exp_cnt = exp_cnt + 1'b1;
      if (c == 29) begin
        total++;
        if (instr_count !== 4'd15) begin
          bad++;
          $display("FAIL jwrap pre: cnt=%0d exp 15", instr_count);
        end
      end
    end
    run = 1'b0;
    tick();
    total++;
    if (instr_count !== 4'd0) begin
      bad++;
      $display("FAIL jwrap end: cnt=%0d exp 0", instr_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_control = C_LW;
    run = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL mid pre: st=%0d exp 3", state);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || w_reg !== 1'b0 || store !== 1'b0
        || instr_count !== '0) begin
      bad++;
      $display("FAIL mid async: st=%0d wr=%b s=%b cnt=%0d exp 0",
               state, w_reg, store, instr_count);
    end
    tick();
    total++;
    if (w_reg !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL mid hold: wr=%b st=%0d exp 0", w_reg, state);
    end
    rst = 1'b1;
    exp_cnt = '0;
    step_instr("lw_restart", C_LW, 6'd0, 5, '{0, 1, 2, 3, 4, 0},
               6'b10000, 6'b10000, 6'b00000, 6'b00000);
  endtask

  task automatic test_illegal();
    op_control = C_R;
    funct_control = C_SUB;
    run = 1'b1;
    tick();
    total++;
    if (state !== 3'd1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL ill dec: st=%0d ill=%b exp 1/0", state, illegal);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (state !== 3'd5 || illegal !== 1'b1 || store !== 1'b0
          || w_reg !== 1'b0 || w_data !== 1'b0
          || instr_count !== exp_cnt) begin
        bad++;
        $display("FAIL ill halt c%0d: st=%0d ill=%b s=%b wr=%b wd=%b cnt=%0d exp 5/1 cnt=%0d",
                 c, state, illegal, store, w_reg, w_data, instr_count,
                 exp_cnt);
      end
    end
    run = 1'b0;
    do_reset();
    total++;
    if (illegal !== 1'b0 || state !== 3'd0 || instr_count !== '0) begin
      bad++;
      $display("FAIL ill clear: ill=%b st=%0d cnt=%0d exp 0",
               illegal, state, instr_count);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = '0;
    test_reset();
    test_idle();
    test_lw();
    test_sw();
    test_beq();
    test_add();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter: CNT_W, default 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  start/continue enable; sampled only in FETCH.
REQ-005 op_control  input  6  opcode of current instruction from datapath (com[31:26]).
REQ-006 funct_control  input  6  R-type funct from datapath (com[5:0]).
REQ-007 zero  input  1  ALU zero flag from datapath; used by datapath for BEQ, not by FSM.
REQ-008 store  output  1  PC write enable to datapath.
REQ-009 w_reg  output  1  register-file write enable.
REQ-010 w_data  output  1  data-memory write enable.
REQ-011 op_alu  output  6  ALU operation code.
REQ-012 state  output  3  current FSM state, debug.
REQ-013 illegal  output  1  sticky unsupported-instruction flag.
REQ-014 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-015 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6,7 go to FETCH next cycle with all enables 0.
REQ-016 FETCH: stay while run=0; run=1 -> DECODE.
REQ-017 DECODE: J -> FETCH with store=1; ADDI/LW/SW/BEQ, or R with funct ADD -> EXEC; anything else -> HALT.
REQ-018 EXEC: BEQ -> FETCH with store=1; LW/SW -> MEM; R-ADD/ADDI -> WB.
REQ-019 MEM: SW -> FETCH with w_data=1, store=1; LW -> WB.
REQ-020 WB: w_reg=1, store=1 -> FETCH.
REQ-021 HALT: all enables 0, illegal=1, stay until reset; run ignored.
REQ-022 Cycle counts per instruction: J 2, BEQ 3, ADD/ADDI/SW 4, LW 5.
REQ-023 store, w_reg, w_data combinational from state and op_control; each asserted for exactly one cycle per instruction, never two instructions back-to-back without passing FETCH.
REQ-024 op_alu = ALU_SUB (100010) in DECODE/EXEC for BEQ; else ALU_ADD (100000) in every state, so address and sum are stable in EXEC, MEM and WB.
REQ-025 instr_count increments by 1 on every edge where store=1; wraps from all-ones to 0; unchanged in HALT.
REQ-026 illegal set on DECODE->HALT transition, cleared only by reset.
REQ-027 op_control/funct_control assumed stable between store pulses (PC unchanged); FSM does not latch them.

Reset
REQ-028 rst low: state=FETCH, store=0, w_reg=0, w_data=0, op_alu=ALU_ADD, illegal=0, instr_count=0, immediately and asynchronously.
REQ-029 Reset mid-instruction aborts it: no write enable asserts, count not incremented; first FETCH after release honours run.

Structure
REQ-030 Shared package cpu_defs_pkg holds opcodes (OP_R, OP_J, OP_ADDI, OP_BEQ, OP_LW, OP_SW), FUNCT_ADD, ALU_ADD, ALU_SUB and state encodings; datapath uses the same package.
REQ-031 No sub-module; single always_ff for state/counter/flag, single always_comb for next-state and outputs.

Verification
REQ-032 Reset, run=0 for 5 cycles -> state stays 0, all enables 0, instr_count=0.
REQ-033 run=1, op=100011 (LW) -> states 0,1,2,3,4; w_reg=1 and store=1 only in cycle 5; count 0->1.
REQ-034 run=1, op=101011 (SW) -> w_data=1 and store=1 in cycle 4, w_reg never 1; op=000100 (BEQ) -> op_alu=100010 in EXEC, store=1 in cycle 3.
REQ-035 op=000000 funct=100010 -> HALT (state=5), illegal=1 held 10 cycles with run=1, no enables, count frozen.
REQ-036 CNT_W=4, 16 J instructions with run=1 -> store every 2nd cycle, instr_count wraps 15->0.
REQ-037 rst low during MEM of LW -> outputs reset same cycle, no w_reg pulse; after release with run=1 the instruction restarts from FETCH.
